audioplay_time_counter: RTL

Hardware playback-time counter that generates the mm:ss display values the HEX PIO digit ports (min1/min0/sec1/sec0) are currently written with by software. It counts one-cycle audio sample ticks from the codec path, cascades BCD seconds and minutes, and drives four active-low seven-segment outputs directly. Software controls it through a small Avalon-MM slave: run, clear, preset, blank and overflow status.

---
 rtl/audioplay_time_defs.sv | 41 ++++
 rtl/audioplay_seg7_decode.sv | 12 +
 rtl/audioplay_time_counter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/audioplay_time_defs.sv
// Shared constants for the mm:ss playback time counter.
// Register map, CTRL bits, BCD width and seven-segment codes.
package audioplay_time_defs;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_TIME   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  localparam int CTRL_RUN   = 0;
  localparam int CTRL_CLEAR = 1;
  localparam int CTRL_BLANK = 2;

  localparam int DIGIT_W = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low, bit6=g .. bit0=a, digits 0..9.
  localparam logic [6:0] SEG_TABLE [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  function automatic logic [6:0] seg7_code(
    input logic [DIGIT_W-1:0] d
  );
    if (d <= 4'd9) seg7_code = SEG_TABLE[d];
    else           seg7_code = SEG_BLANK;
  endfunction

  // mm:ss preset is legal only with BCD digits and sec tens <= 5.
  function automatic logic time_ok(
    input logic [15:0] t
  );
    time_ok = (t[3:0]   <= 4'd9) &&
              (t[7:4]   <= 4'd5) &&
              (t[11:8]  <= 4'd9) &&
              (t[15:12] <= 4'd9);
  endfunction

endpackage

// File: rtl/audioplay_seg7_decode.sv
// BCD digit to active-low seven-segment pattern.
// Purely combinational; the parent registers the result.
module audioplay_seg7_decode
  import audioplay_time_defs::*;
(
  input  logic [DIGIT_W-1:0] bcd_i,
  output logic [6:0]         seg_o
);

  assign seg_o = seg7_code(bcd_i);

endmodule

// File: rtl/audioplay_time_counter.sv
// Playback mm:ss counter driven by audio sample ticks.
// Avalon-MM control, BCD cascade, registered 7-seg outputs.
module audioplay_time_counter
  import audioplay_time_defs::*;
#(
  parameter int SAMPLE_RATE = 48000,
  parameter int PRESCALE_W  = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        sample_tick,
  output logic [6:0]  sec0_seg,
  output logic [6:0]  sec1_seg,
  output logic [6:0]  min0_seg,
  output logic [6:0]  min1_seg
);

  localparam logic [PRESCALE_W-1:0] PRE_MAX =
    PRESCALE_W'(SAMPLE_RATE - 1);

  logic                  run_q, run_d;
  logic                  blank_q, blank_d;
  logic                  ovf_q, ovf_d;
  logic [PRESCALE_W-1:0] pre_q, pre_d;
  logic [DIGIT_W-1:0]    s0_q, s0_d;
  logic [DIGIT_W-1:0]    s1_q, s1_d;
  logic [DIGIT_W-1:0]    m0_q, m0_d;
  logic [DIGIT_W-1:0]    m1_q, m1_d;

  logic wr_en, ctrl_wr, time_wr, stat_w1c, clr;
  logic tick_en, pre_wrap, sec_inc, ovf_set;

  logic [6:0] s0_dec, s1_dec, m0_dec, m1_dec;

  logic unused_wdata;
  assign unused_wdata = ^writedata[31:16];

  assign wr_en    = chipselect & ~write_n;
  assign ctrl_wr  = wr_en & (address == ADDR_CTRL);
  assign time_wr  = wr_en & (address == ADDR_TIME) &
                    time_ok(writedata[15:0]);
  assign stat_w1c = wr_en & (address == ADDR_STATUS) &
                    writedata[0];
  assign clr      = ctrl_wr & writedata[CTRL_CLEAR];

  // The tick in a CTRL-write cycle still sees the old run bit.
  assign tick_en  = run_q & sample_tick;
  assign pre_wrap = tick_en & (pre_q == PRE_MAX);
  assign sec_inc  = pre_wrap & ~clr & ~time_wr;

  // Control bits and sticky overflow; a new overflow beats W1C.
  always_comb begin
    run_d   = run_q;
    blank_d = blank_q;
    if (ctrl_wr) begin
      run_d   = writedata[CTRL_RUN];
      blank_d = writedata[CTRL_BLANK];
    end
    ovf_d = ovf_set | (ovf_q & ~stat_w1c);
  end

  // Prescaler: counts enabled ticks, restarted by clear or preset.
  always_comb begin
    pre_d = pre_q;
    if (clr || time_wr) begin
      pre_d = '0;
    end else if (tick_en) begin
      if (pre_wrap) pre_d = '0;
      else          pre_d = pre_q + PRESCALE_W'(1);
    end
  end

  // BCD cascade ss -> mm with clear > preset > increment.
  always_comb begin
    s0_d    = s0_q;
    s1_d    = s1_q;
    m0_d    = m0_q;
    m1_d    = m1_q;
    ovf_set = 1'b0;
    if (clr) begin
      s0_d = '0;
      s1_d = '0;
      m0_d = '0;
      m1_d = '0;
    end else if (time_wr) begin
      s0_d = writedata[3:0];
      s1_d = writedata[7:4];
      m0_d = writedata[11:8];
      m1_d = writedata[15:12];
    end else if (sec_inc) begin
      if (s0_q != 4'd9) begin
        s0_d = s0_q + 4'd1;
      end else begin
        s0_d = '0;
        if (s1_q != 4'd5) begin
          s1_d = s1_q + 4'd1;
        end else begin
          s1_d = '0;
          if (m0_q != 4'd9) begin
            m0_d = m0_q + 4'd1;
          end else begin
            m0_d = '0;
            if (m1_q != 4'd9) begin
              m1_d = m1_q + 4'd1;
            end else begin
              m1_d    = '0;
              ovf_set = 1'b1;
            end
          end
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q   <= 1'b0;
      blank_q <= 1'b0;
      ovf_q   <= 1'b0;
      pre_q   <= '0;
      s0_q    <= '0;
      s1_q    <= '0;
      m0_q    <= '0;
      m1_q    <= '0;
    end else begin
      run_q   <= run_d;
      blank_q <= blank_d;
      ovf_q   <= ovf_d;
      pre_q   <= pre_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      m0_q    <= m0_d;
      m1_q    <= m1_d;
    end
  end

  audioplay_seg7_decode u_dec_s0 (.bcd_i(s0_q), .seg_o(s0_dec));
  audioplay_seg7_decode u_dec_s1 (.bcd_i(s1_q), .seg_o(s1_dec));
  audioplay_seg7_decode u_dec_m0 (.bcd_i(m0_q), .seg_o(m0_dec));
  audioplay_seg7_decode u_dec_m1 (.bcd_i(m1_q), .seg_o(m1_dec));

  // Registered segment drivers, blanked as a group.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sec0_seg <= SEG_TABLE[0];
      sec1_seg <= SEG_TABLE[0];
      min0_seg <= SEG_TABLE[0];
      min1_seg <= SEG_TABLE[0];
    end else if (blank_q) begin
      sec0_seg <= SEG_BLANK;
      sec1_seg <= SEG_BLANK;
      min0_seg <= SEG_BLANK;
      min1_seg <= SEG_BLANK;
    end else begin
      sec0_seg <= s0_dec;
      sec1_seg <= s1_dec;
      min0_seg <= m0_dec;
      min1_seg <= m1_dec;
    end
  end

  // Zero-latency read mux.
  always_comb begin
    readdata = '0;
    unique case (address)
      ADDR_CTRL:   readdata = {29'd0, blank_q, 1'b0, run_q};
      ADDR_TIME:   readdata = {16'd0, m1_q, m0_q, s1_q, s0_q};
      ADDR_STATUS: readdata = {31'd0, ovf_q};
      ADDR_RSVD:   readdata = '0;
    endcase
  end

endmodule
